// File: rtl/ram_1rw_rd_stream.sv
// rtl/ram_1rw_rd_stream.sv - request/response front end for the 2-cycle byte-masked 1RW RAM wrapper
//
// Accepts a valid/ready request stream of reads and masked writes, issues each
// accepted request straight onto the RAM port in the same cycle, and returns
// read data in request order through a small response FIFO. A credit counter
// covers in-flight reads plus FIFO occupancy, so the FIFO can never overflow.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_val/req_rdy     request handshake; req_wr selects write (1) or read (0)
//   req_addr/data/mask  RAM address, write data, byte write enables
//   resp_val/resp_rdy   response handshake; resp_data is read data in order
//   ram_*_a             RAM wrapper port A (en, wr_en, addr, din, wr_mask out;
//                       dout_val, dout in)
//   err                 sticky protocol error (unexpected RAM data or overflow)
module ram_1rw_rd_stream #(
  parameter int DATA_W      = 32,
  parameter int DATA_MASK_W = DATA_W / 8,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int BUF_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_wr,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_data,
  input  logic [DATA_MASK_W-1:0] req_mask,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   ram_en_a,
  output logic                   ram_wr_en_a,
  output logic [ADDR_W-1:0]      ram_addr_a,
  output logic [DATA_W-1:0]      ram_din_a,
  output logic [DATA_MASK_W-1:0] ram_wr_mask_a,
  input  logic                   ram_dout_val_a,
  input  logic [DATA_W-1:0]      ram_dout_a,
  output logic                   err
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(BUF_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);

  logic [CW-1:0] cred_q, cred_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          stage0_q, stage0_d;
  logic          stage1_q, stage1_d;
  logic          orphan_q, orphan_d;
  logic          err_q, err_d;
  logic [DATA_W-1:0] mem_q [BUF_DEPTH];

  logic rd_issue;
  logic push;
  logic pop;
  logic full;
  logic empty;

  // Admission depends only on registered credits, never on the request itself.
  assign req_rdy       = ~rst & (cred_q < CNT_MAX);
  assign ram_en_a      = req_val & req_rdy;
  assign ram_wr_en_a   = ram_en_a & req_wr;
  assign ram_addr_a    = req_addr;
  assign ram_din_a     = req_data;
  assign ram_wr_mask_a = req_mask;

  assign rd_issue = ram_en_a & ~req_wr;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_MAX);
  assign resp_val  = ~empty;
  assign resp_data = mem_q[head_q];
  assign pop       = resp_val & resp_rdy;

  // A read issued the cycle before reset returns its data the cycle after
  // reset; orphan_q marks that slot so the data is dropped without an error.
  assign push = ram_dout_val_a & ~orphan_q;

  assign err = err_q;

  always_comb begin
    stage0_d = rd_issue;
    stage1_d = stage0_q;
    orphan_d = rst & stage0_q;

    cred_d = cred_q;
    if (rd_issue && !pop) begin
      cred_d = cred_q + CW'(1);
    end else if (!rd_issue && pop) begin
      cred_d = cred_q - CW'(1);
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end

    head_d = head_q;
    if (pop) begin
      head_d = (head_q == PTR_LAST) ? '0 : head_q + PW'(1);
    end

    tail_d = tail_q;
    if (push) begin
      tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + PW'(1);
    end

    // Push into a full FIFO is only an error when nothing leaves that cycle.
    err_d = err_q
          | (ram_dout_val_a != (stage1_q | orphan_q))
          | (push & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cred_q   <= '0;
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      stage0_q <= 1'b0;
      stage1_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cred_q   <= cred_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      stage0_q <= stage0_d;
      stage1_q <= stage1_d;
      err_q    <= err_d;
    end
  end

  // orphan_q must be loaded while rst is high, so it has no reset branch.
  always_ff @(posedge clk) begin
    orphan_q <= orphan_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= ram_dout_a;
    end
  end

endmodule

// File: tb/tb_ram_1rw_rd_stream.sv
// tb/tb_ram_1rw_rd_stream.sv - self-checking bench for ram_1rw_rd_stream
module tb_ram_1rw_rd_stream;

  localparam int DW = 32;
  localparam int MW = 4;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_val;
  logic          req_rdy;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [MW-1:0] req_mask;
  logic          resp_val;
  logic          resp_rdy;
  logic [DW-1:0] resp_data;
  logic          ram_en_a;
  logic          ram_wr_en_a;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_din_a;
  logic [MW-1:0] ram_wr_mask_a;
  logic          ram_dout_val_a;
  logic [DW-1:0] ram_dout_a;
  logic          err;

  logic          force_val;
  logic          load;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_1rw_rd_stream #(
    .DATA_W(DW), .DATA_MASK_W(MW), .DEPTH(DEPTH), .ADDR_W(AW), .BUF_DEPTH(BD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
    .ram_en_a(ram_en_a), .ram_wr_en_a(ram_wr_en_a), .ram_addr_a(ram_addr_a),
    .ram_din_a(ram_din_a), .ram_wr_mask_a(ram_wr_mask_a),
    .ram_dout_val_a(ram_dout_val_a), .ram_dout_a(ram_dout_a),
    .err(err)
  );

  // RAM wrapper model: 2-cycle read latency, byte-masked writes, not reset
  // by rst so reads issued before a reset still return late.
  logic [DW-1:0] ram_mem [DEPTH];
  logic          p0_val, p1_val;
  logic [DW-1:0] p0_data, p1_data;

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram_mem[i] <= (i == 5) ? 32'h0000A5A5 : (i == 3) ? 32'h0 : 32'h10000000 + 32'(i);
      end
      p0_val <= 1'b0;
      p1_val <= 1'b0;
    end else begin
      if (ram_en_a && ram_wr_en_a) begin
        for (int b = 0; b < MW; b++) begin
          if (ram_wr_mask_a[b]) ram_mem[ram_addr_a][8*b +: 8] <= ram_din_a[8*b +: 8];
        end
      end
      p0_val <= ram_en_a & ~ram_wr_en_a;
      p1_val <= p0_val;
    end
    p0_data <= ram_mem[ram_addr_a];
    p1_data <= p0_data;
  end

  assign ram_dout_val_a = p1_val | force_val;
  assign ram_dout_a     = p1_data;

  function automatic logic [31:0] exp_word(input int a);
    if (a == 5) return 32'h0000A5A5;
    if (a == 3) return 32'h00FF00FF;
    return 32'h10000000 + 32'(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_val  = 1'b0;
    req_wr   = 1'b0;
    req_addr = '0;
    req_data = '0;
    req_mask = '0;
  endtask

  typedef struct {
    logic        val;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        rdy;
    logic        e_req_rdy;
    logic        e_en;
    logic        e_wr_en;
    logic        e_resp_val;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [12];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int accepted;
    int got;

    vecs[0]  = '{1'b0, 1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 4'd5, 32'h0,        4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000A5A5};
    vecs[5]  = '{1'b0, 1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 4'd3, 32'hFFFFFFFF, 4'b0101, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 4'd3, 32'h0,        4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00FF00FF};
    vecs[11] = '{1'b0, 1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

    rst = 1'b1;
    load = 1'b1;
    force_val = 1'b0;
    resp_rdy = 1'b0;
    idle_inputs();

    // Reset state, with a request presented to show it is not admitted.
    cyc();
    cyc();
    req_val = 1'b1;
    @(negedge clk);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_ram_en", 32'(ram_en_a), 32'd0);
    chk("rst_ram_wr_en", 32'(ram_wr_en_a), 32'd0);
    chk("rst_resp_val", 32'(resp_val), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Single read of addr 5, then masked write + read-after-write of addr 3.
    for (int i = 0; i < 12; i++) begin
      cyc();
      rst = 1'b0;
      load = 1'b0;
      req_val  = vecs[i].val;
      req_wr   = vecs[i].wr;
      req_addr = vecs[i].addr;
      req_data = vecs[i].data;
      req_mask = vecs[i].mask;
      resp_rdy = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_req_rdy", i), 32'(req_rdy), 32'(vecs[i].e_req_rdy));
      chk($sformatf("vec%0d_ram_en", i), 32'(ram_en_a), 32'(vecs[i].e_en));
      chk($sformatf("vec%0d_ram_wr_en", i), 32'(ram_wr_en_a), 32'(vecs[i].e_wr_en));
      chk($sformatf("vec%0d_resp_val", i), 32'(resp_val), 32'(vecs[i].e_resp_val));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'd0);
      if (vecs[i].e_resp_val) chk($sformatf("vec%0d_resp_data", i), resp_data, vecs[i].e_data);
    end

    // Back-to-back reads of addrs 0..15 with resp_rdy held high.
    for (int c = 0; c < 20; c++) begin
      cyc();
      resp_rdy = 1'b1;
      req_val  = (c < 16);
      req_wr   = 1'b0;
      req_addr = 4'(c);
      @(negedge clk);
      if (c < 16) chk($sformatf("b2b_req_rdy_c%0d", c), 32'(req_rdy), 32'd1);
      if (c >= 3 && c < 19) begin
        chk($sformatf("b2b_resp_val_c%0d", c), 32'(resp_val), 32'd1);
        chk($sformatf("b2b_resp_data_c%0d", c), resp_data, exp_word(c - 3));
      end else begin
        chk($sformatf("b2b_resp_val_c%0d", c), 32'(resp_val), 32'd0);
      end
    end

    // Backpressure: exactly BD reads admitted, then one pop frees one credit.
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      resp_rdy = 1'b0;
      req_val  = 1'b1;
      req_wr   = 1'b0;
      req_addr = 4'(accepted);
      @(negedge clk);
      chk($sformatf("bp_req_rdy_c%0d", c), 32'(req_rdy), (c < 4) ? 32'd1 : 32'd0);
      if (req_rdy) accepted++;
    end
    chk("bp_accepted", 32'(accepted), 32'd4);
    chk("bp_resp_val", 32'(resp_val), 32'd1);
    chk("bp_head_data", resp_data, exp_word(0));

    cyc();
    req_val = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    chk("bp_pop_cycle_req_rdy", 32'(req_rdy), 32'd0);
    chk("bp_pop_data", resp_data, exp_word(0));

    cyc();
    resp_rdy = 1'b0;
    @(negedge clk);
    chk("bp_after_pop_req_rdy", 32'(req_rdy), 32'd1);
    chk("bp_after_pop_data", resp_data, exp_word(1));
    cyc();
    @(negedge clk);
    chk("bp_hold_resp_val", 32'(resp_val), 32'd1);
    chk("bp_hold_data", resp_data, exp_word(1));

    got = 1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      resp_rdy = 1'b1;
      @(negedge clk);
      if (resp_val) begin
        chk($sformatf("bp_drain_data%0d", got), resp_data, exp_word(got));
        got++;
      end
    end
    chk("bp_drain_count", 32'(got), 32'd4);
    chk("bp_drain_empty", 32'(resp_val), 32'd0);

    // Reset with three reads in flight; the late return must be dropped quietly.
    for (int c = 0; c < 3; c++) begin
      cyc();
      resp_rdy = 1'b1;
      req_val  = 1'b1;
      req_wr   = 1'b0;
      req_addr = 4'(6 + c);
      @(negedge clk);
      chk($sformatf("mid_req_rdy_c%0d", c), 32'(req_rdy), 32'd1);
    end
    cyc();
    rst = 1'b1;
    req_val = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_rdy", 32'(req_rdy), 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_after_resp_val", 32'(resp_val), 32'd0);
    chk("mid_after_req_rdy", 32'(req_rdy), 32'd1);
    chk("mid_after_err", 32'(err), 32'd0);
    cyc();
    req_val = 1'b1;
    req_addr = 4'd9;
    @(negedge clk);
    chk("mid_read9_en", 32'(ram_en_a), 32'd1);
    chk("mid_read9_resp_val", 32'(resp_val), 32'd0);
    chk("mid_read9_err", 32'(err), 32'd0);
    for (int c = 0; c < 2; c++) begin
      cyc();
      req_val = 1'b0;
      @(negedge clk);
      chk($sformatf("mid_wait%0d_resp_val", c), 32'(resp_val), 32'd0);
      chk($sformatf("mid_wait%0d_err", c), 32'(err), 32'd0);
    end
    cyc();
    @(negedge clk);
    chk("mid_read9_resp_val_t3", 32'(resp_val), 32'd1);
    chk("mid_read9_data", resp_data, exp_word(9));
    chk("mid_read9_err_t3", 32'(err), 32'd0);

    // Credits fully restored after reset: BD reads admitted under backpressure.
    accepted = 0;
    for (int c = 0; c < 7; c++) begin
      cyc();
      resp_rdy = 1'b0;
      req_val  = 1'b1;
      req_addr = 4'(10 + accepted);
      @(negedge clk);
      if (req_rdy) accepted++;
    end
    chk("mid_cred_accepted", 32'(accepted), 32'd4);
    for (int c = 0; c < 8; c++) begin
      cyc();
      req_val = 1'b0;
      resp_rdy = 1'b1;
      @(negedge clk);
    end
    chk("mid_cred_drained", 32'(resp_val), 32'd0);
    chk("mid_cred_err", 32'(err), 32'd0);

    // Protocol error: RAM data with no read outstanding.
    cyc();
    force_val = 1'b1;
    @(negedge clk);
    chk("perr_same_cycle", 32'(err), 32'd0);
    for (int c = 0; c < 4; c++) begin
      cyc();
      force_val = 1'b0;
      @(negedge clk);
      chk($sformatf("perr_sticky%0d", c), 32'(err), 32'd1);
    end
    cyc();
    rst = 1'b1;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("perr_cleared", 32'(err), 32'd0);
    chk("perr_resp_val", 32'(resp_val), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
